// File: rtl/imm_gen_stage_if.sv
// Purpose : fetch->decode bundle for imm_gen_stage (upstream request, downstream result, flush).
// Latency : n/a (wires only).
// Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
//
// Ports (signals):
//   flush                       pipeline flush from the controlling side
//   in_valid/in_ready           upstream handshake; in_instr (32b), in_pc (XLEN)
//   out_valid/out_ready         downstream handshake; out_imm, out_type, out_pc,
//                               out_target, out_illegal
//   illegal_count               saturating count of accepted illegal opcodes
// master = the surrounding pipeline (drives inputs), slave = the stage itself.
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_target;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_pc, out_target,
           out_illegal, illegal_count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_pc, out_target,
           out_illegal, illegal_count
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Purpose : registered RV immediate generator between fetch and decode, with PC-relative target.
// Latency : 1 cycle from input transfer to out_valid when the stage is empty.
// Backpressure: 2-entry (main + skid) buffer; in_ready is a flop (!skid valid), no comb path from out_ready.
//
// Ports:
//   CLK    rising-edge clock
//   RST_N  synchronous active-low reset (overrides flush)
//   bus    imm_gen_stage_if.slave: flush, in_* request, out_* result, illegal_count
// out_type encoding: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  imm_gen_stage_if.slave bus
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      typ;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            illegal;
  } res_t;

  // ---------------------------------------------------------------
  // Decode (combinational, on the incoming word)
  // ---------------------------------------------------------------
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;
  logic            is_shift;
  res_t            dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm32       = 32'd0;
    dec_type    = T_NONE;
    dec_illegal = 1'b0;
    is_shift    = 1'b0;
    unique case (opcode)
      7'b0110111, 7'b0010111: begin // LUI, AUIPC
        dec_type = T_U;
        imm32    = {instr[31:12], 12'd0};
      end
      7'b1101111: begin // JAL
        dec_type = T_J;
        imm32    = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      end
      7'b1100111, 7'b0000011, 7'b1110011: begin // JALR, LOAD, SYSTEM
        dec_type = T_I;
        imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      7'b0010011: begin // OP-IMM
        dec_type = T_I;
        imm32    = {{20{instr[31]}}, instr[31:20]};
        is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
      end
      7'b1100011: begin // BRANCH
        dec_type = T_B;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      end
      7'b0100011: begin // STORE
        dec_type = T_S;
        imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase

    // Sign-extend the 32-bit form up to XLEN.
    dec_imm       = {XLEN{imm32[31]}};
    dec_imm[31:0] = imm32;

    // Shifts carry a zero-extended shamt instead of a signed immediate;
    // bits above the shamt (funct7, e.g. the SRAI marker) are not part of it.
    if (is_shift) begin
      dec_imm      = '0;
      dec_imm[5:0] = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};
    end
  end

  always_comb begin
    dec.imm     = dec_imm;
    dec.typ     = dec_type;
    dec.pc      = bus.in_pc;
    dec.target  = bus.in_pc + dec_imm;
    dec.illegal = dec_illegal;
  end

  // ---------------------------------------------------------------
  // Main + skid buffer
  // ---------------------------------------------------------------
  res_t             main_q, main_d;
  res_t             skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic             in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = main_vld_q && bus.out_ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;

    if (bus.flush) begin
      // Data registers keep their contents; only occupancy is dropped.
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_xfer) begin
      if (skid_vld_q) begin
        // in_ready was low (skid full), so no input can arrive this cycle.
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_xfer) begin
        main_d = dec;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_vld_q) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!bus.flush && in_xfer && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      // Registered ready: look at the skid occupancy we are about to have.
      in_ready_q <= !skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.out_valid     = main_vld_q;
  assign bus.out_imm       = main_q.imm;
  assign bus.out_type      = main_q.typ;
  assign bus.out_pc        = main_q.pc;
  assign bus.out_target    = main_q.target;
  assign bus.out_illegal   = main_q.illegal;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Purpose : directed self-checking bench for imm_gen_stage (XLEN=32, XLEN=64, CNT_W=2 instances).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: out_ready driven per scenario; in_ready observed before each edge.
module tb_imm_gen_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.XLEN(32), .CNT_W(16)) if32 ();
  imm_gen_stage_if #(.XLEN(64), .CNT_W(16)) if64 ();
  imm_gen_stage_if #(.XLEN(32), .CNT_W(2))  ifc  ();

  imm_gen_stage #(.XLEN(32), .CNT_W(16)) u_d32 (.CLK(clk), .RST_N(rst_n), .bus(if32));
  imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_d64 (.CLK(clk), .RST_N(rst_n), .bus(if64));
  imm_gen_stage #(.XLEN(32), .CNT_W(2))  u_dc2 (.CLK(clk), .RST_N(rst_n), .bus(ifc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // XLEN=32 directed vectors: instr, pc, expected imm / type / illegal.
  localparam logic [31:0] T_INSTR [9] = '{32'hFFF00093, 32'hFE112E23, 32'hFF9FF06F,
                                          32'h123452B7, 32'hFE000CE3, 32'h00001017,
                                          32'h03F09093, 32'h40505093, 32'h0000007F};
  localparam logic [31:0] T_PC    [9] = '{32'h100, 32'h200, 32'h100, 32'h1000, 32'h300,
                                          32'h100, 32'h0,   32'h0,   32'h400};
  localparam logic [31:0] T_IMM   [9] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                          32'h12345000, 32'hFFFFFFF8, 32'h00001000,
                                          32'h0000001F, 32'h00000005, 32'h00000000};
  localparam logic [2:0]  T_TYPE  [9] = '{3'd1, 3'd2, 3'd5, 3'd4, 3'd3, 3'd4, 3'd1, 3'd1, 3'd0};
  localparam logic        T_ILL   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  // XLEN=64 directed vectors.
  localparam logic [31:0] W_INSTR [4] = '{32'h800002B7, 32'h03F09093, 32'hFFF00093, 32'hFF9FF06F};
  localparam logic [63:0] W_PC    [4] = '{64'h0, 64'h0, 64'h100, 64'h100};
  localparam logic [63:0] W_IMM   [4] = '{64'hFFFFFFFF80000000, 64'h3F,
                                          64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8};
  localparam logic [2:0]  W_TYPE  [4] = '{3'd4, 3'd1, 3'd1, 3'd5};

  // Streams four addi (imm 1..4) through the XLEN=32 instance, holding
  // out_ready low for the first 'stall' cycles; checks order and returns
  // the cycle count until the fourth result leaves.
  task automatic stream32(input int stall, output int cycles);
    int n_in;
    int n_out;
    n_in   = 0;
    n_out  = 0;
    cycles = 0;
    for (int c = 0; c < 40 && n_out < 4; c++) begin
      @(negedge clk);
      if32.out_ready = (c >= stall);
      if32.in_valid  = (n_in < 4);
      if32.in_instr  = {12'(n_in + 1), 20'h00093};
      if32.in_pc     = 32'h0;
      if (stall > 0 && c == 2) begin
        chk("bp_in_ready_low", 64'(if32.in_ready), 64'd0);
        chk("bp_accepted", 64'(n_in), 64'd2);
      end
      if (if32.out_valid && if32.out_ready) begin
        chk($sformatf("stream_order_%0d", n_out), 64'(if32.out_imm), 64'(n_out + 1));
        n_out++;
      end
      if (if32.in_valid && if32.in_ready) n_in++;
      cycles = c + 1;
    end
    chk("stream_all_out", 64'(n_out), 64'd4);
    if32.in_valid = 1'b0;
  endtask

  // Leaves the XLEN=32 instance with main = a, skid = b, out_ready low.
  task automatic fill32(input logic [31:0] a, input logic [31:0] pa, input logic [31:0] b);
    @(negedge clk);
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1;
    if32.in_instr  = a;
    if32.in_pc     = pa;
    @(negedge clk);
    if32.in_instr  = b;
    if32.in_pc     = 32'h0;
    @(negedge clk);
    if32.in_valid  = 1'b0;
    chk("fill_in_ready", 64'(if32.in_ready), 64'd0);
    chk("fill_out_valid", 64'(if32.out_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] tgt;

    if32.flush = 0; if32.in_valid = 0; if32.in_instr = 0; if32.in_pc = 0; if32.out_ready = 0;
    if64.flush = 0; if64.in_valid = 0; if64.in_instr = 0; if64.in_pc = 0; if64.out_ready = 0;
    ifc.flush  = 0; ifc.in_valid  = 0; ifc.in_instr  = 0; ifc.in_pc  = 0; ifc.out_ready  = 0;

    // ---- reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("rst_in_ready", 64'(if32.in_ready), 64'd0);
    chk("rst_count", 64'(if32.illegal_count), 64'd0);
    chk("rst_imm", 64'(if32.out_imm), 64'd0);
    chk("rst_in_ready_64", 64'(if64.in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(if32.in_ready), 64'd1);
    chk("post_rst_in_ready_c2", 64'(ifc.in_ready), 64'd1);

    // ---- XLEN=64 widths
    for (int i = 0; i < 4; i++) begin
      if64.out_ready = 1'b1;
      if64.in_valid  = 1'b1;
      if64.in_instr  = W_INSTR[i];
      if64.in_pc     = W_PC[i];
      @(negedge clk);
      chk($sformatf("x64_%0d_vld", i), 64'(if64.out_valid), 64'd1);
      chk($sformatf("x64_%0d_imm", i), if64.out_imm, W_IMM[i]);
      chk($sformatf("x64_%0d_type", i), 64'(if64.out_type), 64'(W_TYPE[i]));
      chk($sformatf("x64_%0d_target", i), if64.out_target, W_PC[i] + W_IMM[i]);
    end
    if64.in_valid = 1'b0;

    // ---- counter saturation (CNT_W=2)
    for (int i = 0; i < 5; i++) begin
      ifc.out_ready = 1'b1;
      ifc.in_valid  = 1'b1;
      ifc.in_instr  = 32'h0000007F;
      @(negedge clk);
      chk($sformatf("sat_count_%0d", i), 64'(ifc.illegal_count), (i + 1 > 3) ? 64'd3 : 64'(i + 1));
    end
    ifc.in_valid = 1'b0;

    // ---- XLEN=32 decode table, back-to-back with out_ready high
    for (int i = 0; i < 9; i++) begin
      if32.out_ready = 1'b1;
      if32.in_valid  = 1'b1;
      if32.in_instr  = T_INSTR[i];
      if32.in_pc     = T_PC[i];
      @(negedge clk);
      tgt = T_PC[i] + T_IMM[i];
      chk($sformatf("t32_%0d_vld", i), 64'(if32.out_valid), 64'd1);
      chk($sformatf("t32_%0d_imm", i), 64'(if32.out_imm), 64'(T_IMM[i]));
      chk($sformatf("t32_%0d_type", i), 64'(if32.out_type), 64'(T_TYPE[i]));
      chk($sformatf("t32_%0d_target", i), 64'(if32.out_target), 64'(tgt));
      chk($sformatf("t32_%0d_pc", i), 64'(if32.out_pc), 64'(T_PC[i]));
      chk($sformatf("t32_%0d_illegal", i), 64'(if32.out_illegal), 64'(T_ILL[i]));
    end
    chk("illegal_count_1", 64'(if32.illegal_count), 64'd1);

    // ---- same illegal word under flush: discarded, not counted
    if32.flush = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(if32.out_valid), 64'd0);
    chk("flush_in_ready", 64'(if32.in_ready), 64'd1);
    chk("flush_count_held", 64'(if32.illegal_count), 64'd1);
    if32.flush    = 1'b0;
    if32.in_valid = 1'b0;

    // ---- throughput and backpressure
    stream32(0, cyc);
    chk("nobubble_cycles", 64'(cyc), 64'd5);
    stream32(3, cyc);
    chk("backpressure_cycles", 64'(cyc), 64'd7);

    // ---- flush with two entries buffered, then a fresh entry
    fill32(32'h00500093, 32'h0, 32'h00600093);
    if32.flush = 1'b1;
    @(negedge clk);
    chk("flush2_out_valid", 64'(if32.out_valid), 64'd0);
    chk("flush2_in_ready", 64'(if32.in_ready), 64'd1);
    if32.flush    = 1'b0;
    if32.in_valid = 1'b1;
    if32.in_instr = 32'h00700093;
    @(negedge clk);
    chk("after_flush_vld", 64'(if32.out_valid), 64'd1);
    chk("after_flush_imm", 64'(if32.out_imm), 64'd7);
    if32.in_valid  = 1'b0;
    if32.out_ready = 1'b1;
    @(negedge clk);

    // ---- reset mid-stream with two entries buffered
    fill32(32'h0000007F, 32'h40, 32'h00800093);
    chk("pre_rst_illegal", 64'(if32.out_illegal), 64'd1);
    chk("pre_rst_count", 64'(if32.illegal_count), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 64'(if32.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(if32.in_ready), 64'd0);
    chk("mid_rst_imm", 64'(if32.out_imm), 64'd0);
    chk("mid_rst_type", 64'(if32.out_type), 64'd0);
    chk("mid_rst_pc", 64'(if32.out_pc), 64'd0);
    chk("mid_rst_target", 64'(if32.out_target), 64'd0);
    chk("mid_rst_illegal", 64'(if32.out_illegal), 64'd0);
    chk("mid_rst_count", 64'(if32.illegal_count), 64'd0);
    @(negedge clk);
    chk("mid_rst_in_ready_2", 64'(if32.in_ready), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", 64'(if32.in_ready), 64'd1);
    chk("rel_out_valid", 64'(if32.out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
